// File: rtl/register_file_2r1w.sv
// Two-read/one-write register file with byte enables, optional zero entry,
// optional write-to-read forwarding and a one-entry-per-cycle clear sweep.
module register_file_2r1w #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter bit R0_ZERO = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              clr,
  output logic              busy,
  output logic              dbg_state
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic                busy_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic                wr_eff;

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_v,
                                              input logic [DATA_W-1:0] new_v,
                                              input logic [NB-1:0]     be);
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int b = 0; b < NB; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  // Writes are dropped while sweeping and entry 0 is never written when hardwired.
  assign wr_eff = we && !busy_q && !(R0_ZERO && (waddr == '0));

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (wr_eff) mem_d[waddr] = merge(mem_q[waddr], wdata, wbe);
    if (state_q == SWEEP) mem_d[ptr_q] = '0;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) mem_q[i] <= '0;
      else     mem_q[i] <= mem_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr) begin
            state_q <= SWEEP;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SWEEP: begin
          ptr_q <= ptr_q + ADDR_W'(1);
          if (ptr_q == {ADDR_W{1'b1}}) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rdata_a = mem_q[raddr_a];
    if (BYPASS && wr_eff && (waddr == raddr_a)) rdata_a = merge(mem_q[raddr_a], wdata, wbe);
    if (R0_ZERO && (raddr_a == '0)) rdata_a = '0;
  end

  always_comb begin
    rdata_b = mem_q[raddr_b];
    if (BYPASS && wr_eff && (waddr == raddr_b)) rdata_b = merge(mem_q[raddr_b], wdata, wbe);
    if (R0_ZERO && (raddr_b == '0)) rdata_b = '0;
  end

  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_register_file_2r1w.sv
// Bench for register_file_2r1w: a forwarding instance and a non-forwarding
// instance share one stimulus stream; vectors plus clear/reset sequences.
module tb_register_file_2r1w;

  logic        clk = 1'b0;
  logic        rst, we, clr;
  logic [4:0]  waddr, raddr_a, raddr_b;
  logic [31:0] wdata;
  logic [3:0]  wbe;
  logic [31:0] rdata_a, rdata_b, nb_rdata_a, nb_rdata_b;
  logic        busy, nb_busy, dbg_state, nb_dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  register_file_2r1w #(.DATA_W(32), .ADDR_W(5), .R0_ZERO(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .raddr_a(raddr_a), .rdata_a(rdata_a), .raddr_b(raddr_b), .rdata_b(rdata_b),
    .clr(clr), .busy(busy), .dbg_state(dbg_state)
  );

  register_file_2r1w #(.DATA_W(32), .ADDR_W(5), .R0_ZERO(1'b1), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .raddr_a(raddr_a), .rdata_a(nb_rdata_a), .raddr_b(raddr_b), .rdata_b(nb_rdata_b),
    .clr(clr), .busy(nb_busy), .dbg_state(nb_dbg_state)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] na;
    logic [31:0] nb;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  task automatic idle_inputs();
    we = 1'b0; clr = 1'b0; waddr = '0; wdata = '0; wbe = '0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    idle_inputs();
    we = 1'b1; waddr = a; wdata = d; wbe = 4'hF;
  endtask

  task automatic check_all_zero(input string name);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      idle_inputs();
      raddr_a = 5'(k); raddr_b = 5'(31 - k);
      #1;
      check($sformatf("%s_a[%0d]", name, k), rdata_a, 32'h0);
      check($sformatf("%s_nb[%0d]", name, k), nb_rdata_b, 32'h0);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; raddr_a = '0; raddr_b = '0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    raddr_a = 5'd5; raddr_b = 5'd31;
    #1;
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_rd_a", rdata_a, 32'h0);
    check("reset_rd_b", rdata_b, 32'h0);

    //          we    wa     wd            be    ra     rb     ea            eb            na            nb
    vecs[0]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 5'd0, 5'd0, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[1]  = '{1'b1, 5'd1, 32'hFFFFFFFF, 4'hF, 5'd1, 5'd0, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[2]  = '{1'b1, 5'd2, 32'hFFFFFFFF, 4'hF, 5'd2, 5'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF};
    vecs[3]  = '{1'b1, 5'd3, 32'hFFFFFFFF, 4'hF, 5'd3, 5'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF};
    vecs[4]  = '{1'b1, 5'd4, 32'hFFFFFFFF, 4'hF, 5'd4, 5'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF};
    vecs[5]  = '{1'b1, 5'd5, 32'hFFFFFFFF, 4'hF, 5'd5, 5'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF};
    vecs[6]  = '{1'b0, 5'd0, 32'h0,        4'h0, 5'd0, 5'd0, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[7]  = '{1'b0, 5'd0, 32'h0,        4'h0, 5'd1, 5'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[8]  = '{1'b0, 5'd0, 32'h0,        4'h0, 5'd2, 5'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,        4'h0, 5'd3, 5'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[10] = '{1'b0, 5'd0, 32'h0,        4'h0, 5'd4, 5'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[11] = '{1'b0, 5'd0, 32'h0,        4'h0, 5'd5, 5'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[12] = '{1'b1, 5'd3, 32'h12345678, 4'h5, 5'd3, 5'd3, 32'hFF34FF78, 32'hFF34FF78, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[13] = '{1'b0, 5'd0, 32'h0,        4'h0, 5'd3, 5'd3, 32'hFF34FF78, 32'hFF34FF78, 32'hFF34FF78, 32'hFF34FF78};
    vecs[14] = '{1'b1, 5'd7, 32'hA5A5A5A5, 4'hF, 5'd7, 5'd3, 32'hA5A5A5A5, 32'hFF34FF78, 32'h00000000, 32'hFF34FF78};
    vecs[15] = '{1'b0, 5'd0, 32'h0,        4'h0, 5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[16] = '{1'b1, 5'd6, 32'hDEADBEEF, 4'h0, 5'd6, 5'd6, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[17] = '{1'b1, 5'd6, 32'hDEADBEEF, 4'h8, 5'd6, 5'd7, 32'hDE000000, 32'hA5A5A5A5, 32'h00000000, 32'hA5A5A5A5};
    vecs[18] = '{1'b0, 5'd0, 32'h0,        4'h0, 5'd6, 5'd0, 32'hDE000000, 32'h00000000, 32'hDE000000, 32'h00000000};
    vecs[19] = '{1'b1, 5'd0, 32'h12345678, 4'hF, 5'd0, 5'd0, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};

    foreach (vecs[i]) begin
      @(negedge clk);
      idle_inputs();
      we = vecs[i].we; waddr = vecs[i].wa; wdata = vecs[i].wd; wbe = vecs[i].be;
      raddr_a = vecs[i].ra; raddr_b = vecs[i].rb;
      #1;
      check($sformatf("vec%0d_a", i), rdata_a, vecs[i].ea);
      check($sformatf("vec%0d_b", i), rdata_b, vecs[i].eb);
      check($sformatf("vec%0d_nb_a", i), nb_rdata_a, vecs[i].na);
      check($sformatf("vec%0d_nb_b", i), nb_rdata_b, vecs[i].nb);
    end

    // clr together with a write: the write lands (and forwards), then gets swept.
    @(negedge clk);
    idle_inputs();
    clr = 1'b1; we = 1'b1; waddr = 5'd9; wdata = 32'h00000099; wbe = 4'hF;
    raddr_a = 5'd9; raddr_b = 5'd9;
    #1;
    check("clr_wr_fwd", rdata_a, 32'h00000099);
    check("clr_wr_busy0", {31'b0, busy}, 32'h0);

    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      idle_inputs();
      raddr_a = 5'd9; raddr_b = 5'd2;
      if (n == 5) begin
        we = 1'b1; waddr = 5'd9; wdata = 32'h11111111; wbe = 4'hF;
      end
      if (n == 20) clr = 1'b1;
      #1;
      if (n == 5) begin
        check("sweep_no_fwd", rdata_a, 32'h00000099);
        check("sweep_partial", rdata_b, 32'h0);
        check("sweep_state", {31'b0, dbg_state}, 32'h1);
      end
      if (!busy) break;
      n++;
    end
    check("sweep_len", 32'(n), 32'd32);
    check("sweep_state_idle", {31'b0, dbg_state}, 32'h0);
    check_all_zero("after_sweep");

    // Reset in the middle of a sweep.
    do_write(5'd20, 32'h00001234);
    do_write(5'd31, 32'hCAFEF00D);
    @(negedge clk);
    idle_inputs();
    clr = 1'b1;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      idle_inputs();
      if (n == 10) rst = 1'b1;
      #1;
      if (n == 10 || !busy) break;
      n++;
    end
    check("rst_at_cycle", 32'(n), 32'd10);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_busy0", {31'b0, busy}, 32'h0);
    @(negedge clk);
    #1;
    check("rst_busy_stays0", {31'b0, busy}, 32'h0);
    check_all_zero("after_rst");

    do_write(5'd4, 32'h0BADC0DE);
    @(negedge clk);
    idle_inputs();
    raddr_a = 5'd4; raddr_b = 5'd4;
    #1;
    check("post_rst_wr_a", rdata_a, 32'h0BADC0DE);
    check("post_rst_wr_nb_b", nb_rdata_b, 32'h0BADC0DE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/register_file_2r1w.md
REGISTER_FILE_2R1W -- requirements
Module: register_file_2r1w

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, data width in bits, multiple of 8.
REQ-002 The block SHALL have parameter ADDR_W, default 5, address width; depth DEPTH = 2**ADDR_W.
REQ-003 The block SHALL have parameter R0_ZERO, default 1, 1 = entry 0 hardwired to zero.
REQ-004 The block SHALL have parameter BYPASS, default 1, 1 = write-to-read forwarding on both read ports.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-007 The block SHALL have port we, input, 1, write enable.
REQ-008 The block SHALL have port waddr, input, ADDR_W, write address.
REQ-009 The block SHALL have port wdata, input, DATA_W, write data.
REQ-010 The block SHALL have port wbe, input, DATA_W/8, byte enables; bit i covers wdata[8i+7:8i].
REQ-011 The block SHALL have port raddr_a, input, ADDR_W, read address for port A.
REQ-012 The block SHALL have port rdata_a, output, DATA_W, read data for port A, combinational.
REQ-013 The block SHALL have port raddr_b, input, ADDR_W, read address for port B.
REQ-014 The block SHALL have port rdata_b, output, DATA_W, read data for port B, combinational.
REQ-015 The block SHALL have port clr, input, 1, request to start a clear sweep.
REQ-016 The block SHALL have port busy, output, 1, high while a clear sweep is in progress.

Function
REQ-017 Storage SHALL be DEPTH x DATA_W flops; ports A and B are independent and may address the same entry.
REQ-018 A write is "effective" when we=1, busy=0 and not (R0_ZERO=1 and waddr=0).
REQ-019 An effective write SHALL update, at the rising edge, only the bytes of mem[waddr] whose wbe bit is 1; other bytes are held.
REQ-020 Read data SHALL be mem[raddr] with zero latency; with R0_ZERO=1, raddr=0 SHALL always read 0.
REQ-021 With BYPASS=1, an effective write whose waddr equals a read address SHALL drive that read port, in the same cycle, with wdata bytes where wbe=1 merged over current mem bytes.
REQ-022 With BYPASS=0, a read of the entry being written SHALL return the pre-write contents until the next edge.
REQ-023 Clear FSM states SHALL be IDLE and SWEEP; ADDR_W-bit pointer ptr.
REQ-024 IDLE with clr=1 SHALL go to SWEEP at the next edge with ptr=0; busy SHALL be 1 exactly while in SWEEP.
REQ-025 In SWEEP, each edge SHALL zero mem[ptr] and increment ptr; the edge clearing ptr=DEPTH-1 SHALL return to IDLE with ptr wrapping to 0, giving busy high for exactly DEPTH cycles.
REQ-026 clr asserted during SWEEP SHALL be ignored (no restart, no extension).
REQ-027 we during SWEEP SHALL be dropped with no effect; bypass SHALL be inactive while busy=1.
REQ-028 Reads during SWEEP SHALL return current (partially cleared) contents.
REQ-029 clr and an effective write in the same IDLE cycle SHALL perform the write; the sweep starting next cycle then clears it.

Reset
REQ-030 rst=1 at a rising edge SHALL zero all entries, set state IDLE, ptr=0 and busy=0, overriding we and clr in that cycle.
REQ-031 rst asserted mid-sweep SHALL abort the sweep; busy SHALL be 0 from the next cycle.

Verification (DATA_W=32, ADDR_W=5 unless noted)
REQ-032 Write FFFFFFFF, wbe=F, to addresses 0..5, then read via port A -> address 0 reads 00000000, addresses 1..5 read FFFFFFFF.
REQ-033 Address 3 holds FFFFFFFF; write 12345678 with wbe=0101 -> ports A and B both at address 3 read FF34FF78.
REQ-034 Write A5A5A5A5 to address 7 with raddr_a=7 in the same cycle -> rdata_a=A5A5A5A5 that cycle; BYPASS=0 instance -> old value that cycle, A5A5A5A5 after the edge.
REQ-035 Pulse clr one cycle, then write to address 9 at sweep cycle 5 -> busy high exactly 32 cycles, write dropped, all 32 entries read 00000000 afterwards.
REQ-036 Assert rst at sweep cycle 10 -> busy 0 next cycle, all entries 00000000; a subsequent write to address 4 reads back correctly.
